divisor_restauracion: RTL and testbench

- Sequential unsigned restoring divider, the inverse operation of the team's Booth multiplier.
- Takes a 2N-bit dividend (the width of a multiplier product) and an N-bit divisor, and returns an N-bit quotient and an N-bit remainder after N iteration cycles.
- Single module containing a control FSM plus a datapath (partial-remainder register, quotient/shift register, divisor register).
- Uses the same start/fin handshake as the multiplier, so the two can share one sequencing scheme at the top level.

---
 rtl/divisor_restauracion_if.sv | 25 ++
 rtl/divisor_restauracion.sv | 134 +++++++++++++
 tb/tb_divisor_restauracion.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/divisor_restauracion_if.sv
// Operand/result bundle for the restoring divider: start/fin handshake plus data.
// With DIVISOR_ERROR_EN defined, an extra error flag travels alongside the result.
interface divisor_restauracion_if #(
  parameter int unsigned N = 3
);
  logic [2*N-1:0] dividendo;
  logic [N-1:0]   divisor;
  logic           start;
  logic [N-1:0]   cociente;
  logic [N-1:0]   resto;
  logic           fin;
`ifdef DIVISOR_ERROR_EN
  logic           error;

  modport master (output dividendo, divisor, start,
                  input  cociente, resto, fin, error);
  modport slave  (input  dividendo, divisor, start,
                  output cociente, resto, fin, error);
`else
  modport master (output dividendo, divisor, start,
                  input  cociente, resto, fin);
  modport slave  (input  dividendo, divisor, start,
                  output cociente, resto, fin);
`endif
endinterface

// File: rtl/divisor_restauracion.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor in N cycles.
// Optional DIVISOR_ERROR_EN adds an error flag for divide-by-zero / quotient overflow.
module divisor_restauracion #(
  parameter int unsigned N = 3
) (
  input logic               clk,
  input logic               reset,
  divisor_restauracion_if.slave bus
);
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [N:0]      r, r_n;
  logic [N-1:0]    q, q_n;
  logic [N-1:0]    d, d_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N-1:0]    coc, coc_n;
  logic [N-1:0]    res, res_n;
  logic            fin, fin_n;
  logic            sat, sat_n;
`ifdef DIVISOR_ERROR_EN
  logic            err, err_n;
`endif

  logic [N:0]      r_sh;
  logic [N+1:0]    diff;
  logic [N-1:0]    q_sh;
  logic [N:0]      r_it;
  logic [N-1:0]    q_it;
  logic            bad;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      r     <= '0;
      q     <= '0;
      d     <= '0;
      cnt   <= '0;
      coc   <= '0;
      res   <= '0;
      fin   <= 1'b0;
      sat   <= 1'b0;
`ifdef DIVISOR_ERROR_EN
      err   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      r     <= r_n;
      q     <= q_n;
      d     <= d_n;
      cnt   <= cnt_n;
      coc   <= coc_n;
      res   <= res_n;
      fin   <= fin_n;
      sat   <= sat_n;
`ifdef DIVISOR_ERROR_EN
      err   <= err_n;
`endif
    end
  end

  // Next state, one restoring step and result publication
  always_comb begin
    r_sh = (N+1)'({r, q[N-1]});
    diff = {1'b0, r_sh} - {2'b00, d};
    q_sh = N'({q, 1'b0});
    if (diff[N+1]) begin
      r_it = r_sh;
      q_it = q_sh;
    end else begin
      r_it = diff[N:0];
      q_it = q_sh | N'(1);
    end
    bad = (bus.divisor == '0) || (bus.dividendo[2*N-1:N] >= bus.divisor);

    state_n = state;
    r_n     = r;
    q_n     = q;
    d_n     = d;
    cnt_n   = cnt;
    coc_n   = coc;
    res_n   = res;
    fin_n   = fin;
    sat_n   = sat;
`ifdef DIVISOR_ERROR_EN
    err_n   = err;
`endif

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          r_n     = {1'b0, bus.dividendo[2*N-1:N]};
          q_n     = bus.dividendo[N-1:0];
          d_n     = bus.divisor;
          // Unrepresentable quotients spend a single slot, then publish saturation
          cnt_n   = bad ? CW'(1) : CW'(N);
          sat_n   = bad;
          fin_n   = 1'b0;
          state_n = ITER;
        end
      end
      ITER: begin
        r_n   = r_it;
        q_n   = q_it;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = DONE;
          fin_n   = 1'b1;
          coc_n   = sat ? '1 : q_it;
          res_n   = sat ? '0 : r_it[N-1:0];
`ifdef DIVISOR_ERROR_EN
          err_n   = sat;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.cociente = coc;
  assign bus.resto    = res;
  assign bus.fin      = fin;
`ifdef DIVISOR_ERROR_EN
  assign bus.error    = err;
`endif

endmodule

// File: tb/tb_divisor_restauracion.sv
// Scoreboard bench for divisor_restauracion: directed cases, held-start restarts and random ops.
// Checks the error flag too when DIVISOR_ERROR_EN is defined.
module tb_divisor_restauracion;
  localparam int unsigned N = 3;
  localparam int unsigned W = 2 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;

  divisor_restauracion_if #(.N(N)) bus ();
  divisor_restauracion #(.N(N)) dut (.clk(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         e;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic fin_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division with saturation when the quotient cannot fit
  function automatic exp_t model(int a, int b, int acc);
    exp_t e;
    if (b == 0 || (a / (1 << N)) >= b) begin
      e.q = '1; e.r = '0; e.e = 1'b1; e.cyc = acc + 1;
    end else begin
      e.q = N'(a / b); e.r = N'(a % b); e.e = 1'b0; e.cyc = acc + int'(N);
    end
    return e;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising fin must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.fin && !fin_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fin actual=1 expected=0 (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("cociente", int'(bus.cociente), int'(e.q));
        check("resto", int'(bus.resto), int'(e.r));
        check("latency", cyc, e.cyc);
`ifdef DIVISOR_ERROR_EN
        check("error", int'(bus.error), int'(e.e));
`endif
      end
    end
    fin_prev = bus.fin;
  end

  task automatic issue(int a, int b);
    @(negedge clk);
    bus.dividendo = W'(a);
    bus.divisor   = N'(b);
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(a, b, cyc));
    bus.start = 1'b0;
    check("fin_drop", int'(bus.fin), 0);
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic rand_op(output int a, output int b);
    if ($urandom_range(0, 1) == 0) begin
      b = int'($urandom_range(0, (1 << N) - 1));
      a = int'($urandom_range(0, (1 << W) - 1));
    end else begin
      b = int'($urandom_range(1, (1 << N) - 1));
      a = int'($urandom_range(0, b - 1)) * (1 << N) + int'($urandom_range(0, (1 << N) - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, acc, lat;
    exp_t e;
    bus.dividendo = '0;
    bus.divisor   = '0;
    bus.start     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cociente", int'(bus.cociente), 0);
    check("rst_resto", int'(bus.resto), 0);
    check("rst_fin", int'(bus.fin), 0);
    rst = 1'b0;

    issue(13, 3); drain(20);
    issue(55, 7); drain(20);
    issue(20, 5); drain(20);
    issue(9, 0);  drain(20);
    issue(40, 2); drain(20);
    issue(35, 7); drain(20);

    // Start re-pulsed during ITER must be ignored
    issue(13, 3);
    @(negedge clk);
    bus.dividendo = W'(60);
    bus.divisor   = N'(1);
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain(20);
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-division
    issue(13, 3);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_cociente", int'(bus.cociente), 0);
    check("abort_resto", int'(bus.resto), 0);
    check("abort_fin", int'(bus.fin), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(13, 3); drain(20);

    // Start held high: a new division is accepted on each DONE cycle
    for (int rep = 0; rep < 3; rep++) begin
      rand_op(a, b);
      @(negedge clk);
      bus.dividendo = W'(a);
      bus.divisor   = N'(b);
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      e = model(a, b, acc);
      sb.push_back(e);
      for (int k = 0; k < 4; k++) begin
        lat = e.cyc - acc;
        rand_op(a, b);
        bus.dividendo = W'(a);
        bus.divisor   = N'(b);
        repeat (lat + 1) @(posedge clk);
        #1;
        acc = cyc;
        e = model(a, b, acc);
        sb.push_back(e);
      end
      bus.start = 1'b0;
      drain(60);
    end

    // Random pulsed operations with random idle gaps
    for (int i = 0; i < 40; i++) begin
      rand_op(a, b);
      issue(a, b);
      drain(20);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
